// File: rtl/rom_stream_reader.sv
// rom_stream_reader: reads a burst of ROM words and streams them out over valid/ready
module rom_stream_reader #(
  parameter int AW = 3,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  output logic [AW-1:0] addr1,
  input  logic [DW-1:0] rd1,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, ZERO} state_t;
  state_t        state;
  logic [AW-1:0] ptr;
  logic [AW:0]   rem;
  logic          inflight;
  logic [DW-1:0] buf_mem [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    buf_count;
  logic          pop, issue, last_pop;
  logic [2:0]    credit;
  assign addr1     = ptr;
  assign out_valid = buf_count != 2'd0;
  assign out_data  = buf_mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign credit    = {1'b0, buf_count} + {2'b0, inflight} - {2'b0, pop};
  assign issue     = state == READ && rem != '0 && credit < 3'd2;
  assign last_pop  = state == DRAIN && buf_count == 2'd1 && !inflight && pop;
  assign busy      = state != IDLE;
  assign done      = last_pop || state == ZERO;
  // burst sequencing, address issue with credit check, and 2-entry capture buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      rem        <= '0;
      inflight   <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      buf_count  <= 2'd0;
    end else begin
      if (state == IDLE && start && count != '0) begin
        state <= READ;
        ptr   <= base_addr;
        rem   <= count;
      end else if (state == IDLE && start) begin
        state <= ZERO;
      end else if (state == ZERO || last_pop) begin
        state <= IDLE;
      end
      if (issue) begin
        ptr <= ptr + 1'b1;
        rem <= rem - 1'b1;
        if (rem == {{AW{1'b0}}, 1'b1}) state <= DRAIN;
      end
      inflight <= issue;
      if (inflight) begin
        buf_mem[wr_ptr] <= rd1;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      buf_count <= buf_count + {1'b0, inflight} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: randomized bursts against a queue-based model of the streamed words
module tb_rom_stream_reader;
  localparam int AW = 3;
  localparam int DW = 2;
  logic          clk = 1'b0;
  logic          reset, start, out_ready;
  logic [AW-1:0] base_addr, addr1;
  logic [AW:0]   count;
  logic [DW-1:0] rd1, out_data;
  logic          out_valid, busy, done;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // behavioural ROM: mem[a] = a[1:0], one cycle read latency
  always @(posedge clk) rd1 <= addr1[1:0];

  rom_stream_reader #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .addr1(addr1), .rd1(rd1), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 ready always, 1 pattern 1,0,0,1, 2 random; poke issues a start mid-burst
  task automatic run_burst(input logic [AW-1:0] b, input int n, input int mode, input bit timing, input bit poke);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] prev_data;
    logic [AW-1:0] a, addr0;
    bit prev_stall, seen_done, pop, exp_done, exp_valid;
    int xfers, done_cycle;
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i);
      exp_q.push_back(a[1:0]);
    end
    xfers = 0; seen_done = 0; prev_stall = 0; prev_data = '0; done_cycle = -1;
    addr0 = addr1;
    start = 1'b1; base_addr = b; count = (AW+1)'(n); out_ready = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_c0 got=%b exp=0", busy); end
    for (int c = 1; c <= 300 && !seen_done; c++) begin
      @(posedge clk);
      #1;
      start = poke && c == 2;
      base_addr = b + 3'd3;
      count = 4'd5;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? ((c - 1) % 4 == 0 || (c - 1) % 4 == 3) : 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy c=%0d got=%b exp=1", c, busy); end
      if (n == 0) begin
        checks++;
        if (addr1 !== addr0) begin errors++; $display("FAIL zero_addr got=%0d exp=%0d", addr1, addr0); end
      end else if (c == 1) begin
        checks++;
        if (addr1 !== b) begin errors++; $display("FAIL first_addr got=%0d exp=%0d", addr1, b); end
      end
      if (timing && c <= n) begin
        a = b + AW'(c - 1);
        checks++;
        if (addr1 !== a) begin errors++; $display("FAIL addr c=%0d got=%0d exp=%0d", c, addr1, a); end
      end
      if (timing) begin
        exp_valid = c >= 3 && c <= n + 2;
        checks++;
        if (out_valid !== exp_valid) begin errors++; $display("FAIL valid_timing c=%0d got=%b exp=%b", c, out_valid, exp_valid); end
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++; $display("FAIL stall_hold c=%0d valid=%b data=%0d exp_data=%0d", c, out_valid, out_data, prev_data);
        end
      end
      pop = out_valid === 1'b1 && out_ready;
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL extra_word c=%0d got=%0d", c, out_data);
        end else begin
          a[1:0] = exp_q.pop_front();
          if (out_data !== a[1:0]) begin errors++; $display("FAIL data c=%0d got=%0d exp=%0d", c, out_data, a[1:0]); end
        end
        xfers++;
      end
      exp_done = n == 0 ? c == 1 : pop && xfers == n;
      checks++;
      if (done !== exp_done) begin errors++; $display("FAIL done c=%0d got=%b exp=%b", c, done, exp_done); end
      prev_stall = out_valid === 1'b1 && !out_ready;
      prev_data = out_data;
      seen_done = done === 1'b1;
      if (seen_done) done_cycle = c;
    end
    checks++;
    if (!seen_done || xfers != n || exp_q.size() != 0) begin
      errors++; $display("FAIL burst_end done=%b xfers=%0d exp=%0d left=%0d", seen_done, xfers, n, exp_q.size());
    end
    if (timing) begin
      checks++;
      if (done_cycle != (n == 0 ? 1 : n + 2)) begin errors++; $display("FAIL done_cycle got=%0d exp=%0d", done_cycle, n == 0 ? 1 : n + 2); end
    end
    tick();
    start = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_idle busy=%b done=%b valid=%b exp=0,0,0", busy, done, out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; count = '0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || addr1 !== '0 || out_data !== '0) begin
      errors++; $display("FAIL reset valid=%b busy=%b done=%b addr=%0d data=%0d exp=0", out_valid, busy, done, addr1, out_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_burst(3'd0, 4, 0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    run_burst(3'd6, 4, 0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    run_burst(3'd0, 8, 1, 1'b0, 1'b0);
    run_burst(3'd0, 8, 2, 1'b0, 1'b0);
  endtask

  task automatic test_zero_and_ignored();
    run_burst(3'd5, 0, 0, 1'b1, 1'b0);
    run_burst(3'd1, 6, 0, 1'b1, 1'b1);
    run_burst(3'd2, 7, 2, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; base_addr = 3'd0; count = 4'd8; out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 1'b0;
      if (c == 4) reset = 1'b1;
    end
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || addr1 !== '0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_mid valid=%b busy=%b addr=%0d done=%b exp=0", out_valid, busy, addr1, done);
    end
    run_burst(3'd3, 2, 0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) run_burst(AW'($urandom_range(0, 7)), $urandom_range(0, 8), $urandom_range(0, 2), 1'b0, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_and_ignored();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Upstream address sequencer and downstream stream adapter for the synchronous 8x2 ROM (ROM_v2).
- On a start command, it reads `count` consecutive ROM words beginning at `base_addr`, wrapping modulo 2^AW.
- It drives the ROM address port, captures the read data, and presents the words in order on a valid/ready output stream.
- A 2-entry buffer absorbs the ROM's 1-cycle read latency, so output backpressure never drops or duplicates a word.

Parameters:
- AW, 3, ROM address width; ROM depth is 2^AW.
- DW, 2, ROM data width.

Ports:
- clk  input  1  rising-edge clock, shared with the ROM.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a burst; accepted only in IDLE.
- base_addr  input  AW  first ROM address of the burst; sampled when start is accepted.
- count  input  AW+1  number of words to read (0..2^AW); sampled when start is accepted.
- addr1  output  AW  ROM address; connects to ROM_v2 addr1.
- rd1  input  DW  ROM read data; connects to ROM_v2 rd1.
- out_data  output  DW  stream data, taken from the buffer head.
- out_valid  output  1  stream data valid.
- out_ready  input  1  consumer ready; a transfer occurs when out_valid && out_ready.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- ROM timing (fixed): rd1 in cycle k+1 equals mem[addr1 as driven in cycle k].
- Reset (synchronous, highest priority, including mid-burst):
  - state=IDLE; addr pointer=0, so addr1=0.
  - Buffer emptied; in-flight flag=0; remaining-issue counter=0.
  - out_valid=0, out_data=0, busy=0, done=0.
  - Any word in flight is discarded.
- addr1 is driven combinationally from the address pointer register. In IDLE it holds the last value.
- FSM states:
  - IDLE: start=1 and count!=0 → READ. Load pointer=base_addr, remaining=count, busy=1 from the next cycle.
  - IDLE: start=1 and count==0 → no ROM reads; done=1 and busy=1 for exactly the next cycle, then IDLE.
  - READ: issue occurs in a cycle when remaining!=0 and (buf_count + inflight − pop) < 2, where pop = out_valid && out_ready.
  - On issue: pointer ← pointer+1 (wraps 2^AW−1 → 0), remaining ← remaining−1, inflight ← 1. If no issue, inflight ← 0.
  - READ: when remaining reaches 0 and the last issue has been made → DRAIN.
  - DRAIN: no issues. When the buffer is empty and inflight=0 after the final pop → IDLE, with done=1 in the cycle of that final pop.
- Capture: if inflight=1, rd1 is written to the buffer tail at the end of that cycle.
  - A simultaneous pop and capture is legal and leaves buf_count unchanged.
  - The credit rule guarantees the buffer never overflows.
- out_valid = (buf_count != 0). out_data = buffer head; it is stable while out_valid && !out_ready.
- busy = 1 from the cycle after the start accept through the done cycle inclusive; busy=0 in IDLE otherwise.
- start while busy is ignored (no queueing).
- Latency: start accepted in cycle 0 → addr1=base_addr in cycle 1 → out_valid in cycle 3.
- Throughput: with out_ready held at 1, one word per cycle; a burst of N completes with done in cycle N+2.
- Ordering: words emerge strictly in address order; no loss or duplication under any out_ready pattern.

Test Plan:
The bench uses a behavioural ROM model with mem[a] = a[1:0].
1. Basic burst: reset, then start with base=0, count=4, out_ready=1 → addr1 sequence 0,1,2,3 in cycles 1-4; out_data 0,1,2,3 valid in cycles 3-6; done pulse in cycle 6; busy high cycles 1-6.
2. Wrap-around: base=6, count=4 → addresses 6,7,0,1; outputs 2,3,0,1.
3. Backpressure: count=8, out_ready toggling 1,0,0,1,… and a random pattern → exactly 8 transfers with data 0,1,2,3,0,1,2,3 in order; out_data held while stalled; buf_count never exceeds 2.
4. Zero count and ignored start: count=0 → no addr1 change, done=1 and busy=1 for one cycle only; a start during a busy burst is ignored and the burst completes unchanged.
5. Reset mid-burst: assert reset in cycle 4 of a count=8 burst → next cycle out_valid=0, busy=0, addr1=0, state IDLE; a fresh start with base=3, count=2 then yields outputs 3,0 correctly.
